serial_word_tx: RTL and testbench
=================================

Name: serial_word_tx

Overview:
- Upstream feeder for the 4-bit serial-in shift register stage.
- Accepts parallel words over a valid/ready handshake and buffers one word.
- Serializes each word MSB-first onto `sout`, which drives the shift register's `sin`.
- Qualifies each bit with `shift_en` and flags word completion, so the consumer can sample its parallel output.

Parameters:
- WIDTH, 4: word width in bits; the bit counter is $clog2(WIDTH+1) bits.
- GAP, 0: number of idle cycles forced between consecutive words (0..15).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  holding buffer can accept a word
- in_data  input  WIDTH  parallel word to transmit
- sout  output  1  serial data bit, connects to downstream `sin`
- shift_en  output  1  sout carries a valid bit this cycle
- word_done  output  1  one-cycle pulse on the cycle the last bit of a word is driven
- busy  output  1  FSM not in IDLE, or holding buffer full

Behaviour:
- Reset values (reset low, applied immediately):
  - sout=0, shift_en=0, word_done=0, busy=0, in_ready=1.
  - Buffer empty, shifter=0, counters=0, FSM=IDLE.
  - in_valid is ignored while reset is low.
- Reset mid-word aborts the word; no partial word_done is produced.
- Handshake:
  - Transfer occurs on the edge where in_valid && in_ready.
  - in_ready = !buf_full; it is registered-state derived, with no combinational path from in_valid.
  - The buffer holds exactly one word.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: if buf_full, load shifter<=buf, bitcnt<=WIDTH, clear buf_full, go to SHIFT.
  - SHIFT:
    - Drives sout=shifter[WIDTH-1] and shift_en=1; each edge shifts left (zero-filled) and decrements bitcnt.
    - On the cycle with bitcnt==1, word_done=1.
    - Next state on that edge: if GAP>0, go to GAP with gapcnt=GAP.
    - Otherwise, if buf_full, reload directly and stay in SHIFT, giving zero-bubble back-to-back words.
    - Otherwise go to IDLE.
  - GAP: shift_en=0, sout=0; decrement gapcnt; at gapcnt==1 go to SHIFT if buf_full (reload), else IDLE.
- Latency: a word accepted at edge N while IDLE puts its first bit on sout after edge N+1. Its last bit and word_done occur in the cycle after edge N+WIDTH.
- Throughput: one word per WIDTH+GAP cycles when in_valid is held high.
- Simultaneous accept and drain:
  - A new word may be accepted on the same edge the buffer drains into the shifter only if buf_full was 0 before that edge.
  - Since in_ready reflects the pre-edge state, a full buffer takes one cycle to reopen.
  - No data is lost or duplicated.
- Outside SHIFT: sout=0 and shift_en=0.
- word_done never asserts outside SHIFT.

Optional Feature:
- Macro: SERIAL_WORD_TX_PARITY_EN.
- When defined:
  - Each word is followed by one extra SHIFT cycle carrying the even-parity bit (XOR of the WIDTH data bits), with shift_en=1.
  - The frame is WIDTH+1 bits, bitcnt loads WIDTH+1, and word_done asserts on the parity bit cycle.
- When undefined: frame is WIDTH bits; no parity logic is synthesized.

Decomposition:
- Package serial_word_tx_pkg holds:
  - the FSM state typedef (IDLE, SHIFT, GAP);
  - the default WIDTH/GAP localparams;
  - the frame-length function (WIDTH, or WIDTH+1 with parity).
- One sub-module: serial_word_holdbuf, the 1-entry valid/ready holding register. It exposes buf_full, buf_data and a pop strobe.

Test Plan:
1. Reset then single word: release reset, send in_data=4'b1011.
   - sout is 1,0,1,1 on consecutive cycles, with shift_en high for exactly 4 cycles.
   - word_done pulses with the 4th bit; downstream shift_reg4 q=4'hB afterwards.
2. Back-to-back, GAP=0: hold in_valid with words 4'hA then 4'h5.
   - 8 contiguous shift_en cycles with serial pattern 1010 0101.
   - word_done pulses on the 4th and 8th cycles; no bubble.
3. GAP=2: send 4'hF and 4'h0 back-to-back.
   - 4 shift cycles, then 2 cycles of shift_en=0 and sout=0, then 4 shift cycles.
4. Backpressure: hold in_valid with three words 1,2,3.
   - in_ready deasserts while the buffer is full.
   - All three words are serialized in order; none is dropped or duplicated.
5. Reset mid-word: assert reset after the 2nd bit of 4'hC.
   - All outputs go to reset values immediately; no word_done.
   - After release, next word 4'h3 is transmitted correctly.
6. With SERIAL_WORD_TX_PARITY_EN: send 4'b0111.
   - 5 shift cycles: 0,1,1,1 then parity 1.
   - word_done pulses on the 5th cycle.

Source files
------------

// File: rtl/serial_word_tx_pkg.sv
// Shared types, defaults and frame-length helper for serial_word_tx.
// Optional parity bit per frame: define SERIAL_WORD_TX_PARITY_EN.
package serial_word_tx_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_GAP   = 0;

  // GAP_WAIT rather than GAP so the state name cannot collide with the GAP parameter.
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP_WAIT
  } state_t;

  function automatic int frame_len(input int width);
`ifdef SERIAL_WORD_TX_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/serial_word_holdbuf.sv
// One-entry valid/ready holding register in front of the serializer.
// in_ready depends only on registered state, never on in_valid.
module serial_word_holdbuf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             pop,
  output logic             buf_full,
  output logic [WIDTH-1:0] buf_data
);

  assign in_ready = !buf_full;

  // pop is only ever raised while full, so it never coincides with an accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_full <= 1'b0;
      buf_data <= '0;
    end else if (in_valid && in_ready) begin
      buf_full <= 1'b1;
      buf_data <= in_data;
    end else if (pop) begin
      buf_full <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_word_tx.sv
// MSB-first word serializer feeding a serial-in shift register stage.
// Define SERIAL_WORD_TX_PARITY_EN to append an even-parity bit to every frame.
module serial_word_tx
  import serial_word_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int GAP   = DEFAULT_GAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sout,
  output logic             shift_en,
  output logic             word_done,
  output logic             busy
);

  localparam int FRAME = frame_len(WIDTH);
  localparam int CW    = $clog2(FRAME + 1);

  state_t           state, next_state;
  logic [FRAME-1:0] shifter, load_word;
  logic [CW-1:0]    bitcnt;
  logic [3:0]       gapcnt;
  logic             buf_full, pop, load, last_bit;
  logic [WIDTH-1:0] buf_data;

  serial_word_holdbuf #(.WIDTH(WIDTH)) u_holdbuf (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .pop      (pop),
    .buf_full (buf_full),
    .buf_data (buf_data)
  );

`ifdef SERIAL_WORD_TX_PARITY_EN
  assign load_word = {buf_data, ^buf_data};
`else
  assign load_word = buf_data;
`endif

  assign last_bit = (bitcnt == CW'(1));
  assign busy     = (state != IDLE) || buf_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // A load always drains the buffer, so pop and load move together.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    pop        = 1'b0;
    sout       = 1'b0;
    shift_en   = 1'b0;
    word_done  = 1'b0;
    case (state)
      IDLE: begin
        if (buf_full) begin
          load       = 1'b1;
          pop        = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        sout     = shifter[FRAME-1];
        shift_en = 1'b1;
        if (last_bit) begin
          word_done = 1'b1;
          if (GAP > 0) begin
            next_state = GAP_WAIT;
          end else if (buf_full) begin
            load = 1'b1;
            pop  = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      GAP_WAIT: begin
        if (gapcnt == 4'd1) begin
          if (buf_full) begin
            load       = 1'b1;
            pop        = 1'b1;
            next_state = SHIFT;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // A reload on the final bit takes priority over the normal shift step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shifter <= '0;
      bitcnt  <= '0;
      gapcnt  <= '0;
    end else begin
      if (load) begin
        shifter <= load_word;
        bitcnt  <= CW'(FRAME);
      end else if (state == SHIFT) begin
        shifter <= shifter << 1;
        bitcnt  <= bitcnt - 1'b1;
      end
      if (state == SHIFT && last_bit) gapcnt <= 4'(GAP);
      else if (state == GAP_WAIT)     gapcnt <= gapcnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: GAP=0 and GAP=2 instances, plus a shift_reg4 model.
// Define SERIAL_WORD_TX_PARITY_EN to exercise the parity frame instead of the plain frames.
module tb_serial_word_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       validA = 1'b0, validB = 1'b0;
  logic [3:0] inData = 4'h0;
  logic       readyA, soutA, shiftEnA, wordDoneA, busyA;
  logic       readyB, soutB, shiftEnB, wordDoneB, busyB;
  logic [3:0] qA;
  logic [3:0] txQ[$];
  int         testsRun = 0;
  int         failCount = 0;

  always #5 clk = ~clk;

  serial_word_tx #(.WIDTH(4), .GAP(0)) dutA (
    .clk(clk), .reset(reset), .in_valid(validA), .in_ready(readyA), .in_data(inData),
    .sout(soutA), .shift_en(shiftEnA), .word_done(wordDoneA), .busy(busyA)
  );

  serial_word_tx #(.WIDTH(4), .GAP(2)) dutB (
    .clk(clk), .reset(reset), .in_valid(validB), .in_ready(readyB), .in_data(inData),
    .sout(soutB), .shift_en(shiftEnB), .word_done(wordDoneB), .busy(busyB)
  );

  // Downstream 4-bit serial-in shift register fed by instance A.
  always @(posedge clk or negedge reset) begin
    if (!reset)        qA <= 4'h0;
    else if (shiftEnA) qA <= {qA[2:0], soutA};
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Presents queued words on the selected instance, advancing on each accepted handshake.
  task automatic applyStimulus(input int sel);
    int  guard;
    logic wasReady;
    guard = 0;
    while (txQ.size() > 0 && guard < 40) begin
      inData = txQ[0];
      if (sel == 0) begin validA = 1'b1; wasReady = readyA; end
      else          begin validB = 1'b1; wasReady = readyB; end
      @(negedge clk);
      if (wasReady) void'(txQ.pop_front());
      guard++;
    end
    validA = 1'b0;
    validB = 1'b0;
    checkOutput("drv_drain", txQ.size(), 0);
    txQ.delete();
  endtask

  // Per-cycle expectations, MSB = first sampled cycle: {sout, shift_en, word_done, in_ready}.
  task automatic checkFrame(input int sel, input int n, input logic [15:0] eSout, input logic [15:0] eEn,
                            input logic [15:0] eDone, input logic [15:0] eReady, input string name);
    logic [3:0] obs, exp;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      obs = (sel == 0) ? {soutA, shiftEnA, wordDoneA, readyA} : {soutB, shiftEnB, wordDoneB, readyB};
      exp = {eSout[n-1-k], eEn[n-1-k], eDone[n-1-k], eReady[n-1-k]};
      checkOutput($sformatf("%s_c%0d", name, k), 32'(obs), 32'(exp));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held with in_valid high: nothing may be accepted.
    validA = 1'b1;
    inData = 4'hF;
    repeat (3) @(negedge clk);
    checkOutput("rst_A", {27'd0, soutA, shiftEnA, wordDoneA, busyA, readyA}, 32'b00001);
    checkOutput("rst_B", {27'd0, soutB, shiftEnB, wordDoneB, busyB, readyB}, 32'b00001);
    validA = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_busy", {31'd0, busyA}, 0);

`ifdef SERIAL_WORD_TX_PARITY_EN
    txQ = '{4'b0111};
    fork
      applyStimulus(0);
      checkFrame(0, 7, 16'b0011110, 16'b0111110, 16'b0000010, 16'b0111111, "t6_parity");
    join
`else
    txQ = '{4'hB};
    fork
      applyStimulus(0);
      checkFrame(0, 6, 16'b010110, 16'b011110, 16'b000010, 16'b011111, "t1_single");
    join
    checkOutput("t1_q", 32'(qA), 32'hB);
    repeat (2) @(negedge clk);

    txQ = '{4'hA, 4'h5};
    fork
      applyStimulus(0);
      checkFrame(0, 10, 16'b0101001010, 16'b0111111110, 16'b0000100010, 16'b0100011111, "t2_b2b");
    join
    checkOutput("t2_q", 32'(qA), 32'h5);
    repeat (2) @(negedge clk);

    txQ = '{4'hF, 4'h0};
    fork
      applyStimulus(1);
      checkFrame(1, 12, 16'b011110000000, 16'b011110011110, 16'b000010000010, 16'b010000011111, "t3_gap");
    join
    repeat (2) @(negedge clk);

    txQ = '{4'h1, 4'h2, 4'h3};
    fork
      applyStimulus(0);
      checkFrame(0, 14, 16'b00001001000110, 16'b01111111111110, 16'b00001000100010,
                 16'b01000100011111, "t4_bp");
    join
    checkOutput("t4_busy", {31'd0, busyA}, 0);
    repeat (2) @(negedge clk);

    txQ = '{4'hC};
    fork
      applyStimulus(0);
      checkFrame(0, 3, 16'b011, 16'b011, 16'b000, 16'b011, "t5_pre");
    join
    #1 reset = 1'b0;
    #1 checkOutput("t5_rst_now", {27'd0, soutA, shiftEnA, wordDoneA, busyA, readyA}, 32'b00001);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput($sformatf("t5_hold_c%0d", k), {27'd0, soutA, shiftEnA, wordDoneA, busyA, readyA}, 32'b00001);
    end
    reset = 1'b1;
    @(negedge clk);
    txQ = '{4'h3};
    fork
      applyStimulus(0);
      checkFrame(0, 6, 16'b000110, 16'b011110, 16'b000010, 16'b011111, "t5_after");
    join
    checkOutput("t5_q", 32'(qA), 32'h3);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
